alu_rr_scheduler: RTL and testbench

- Shares one 16-bit `alu` instance between two requesters (e.g. two issue slots or a CPU core plus a debug port).
- Arbitrates with round-robin priority and latches the winner's operands and control onto the ALU ports.
- Captures the ALU result in registers and returns it on a single tagged response channel with a valid/ready handshake.
- Sits between the requesters and the `alu` instance; the ALU itself stays outside this block.

---
 rtl/alu_rr_scheduler.sv | 105 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end sharing one external ALU between two requesters.
// Operands are latched on accept, the ALU result is captured one cycle later and returned on a tagged handshake.
module alu_rr_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_select,
  input  logic             req0_mode,
  input  logic             req0_carry,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_select,
  input  logic             req1_mode,
  input  logic             req1_carry,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry_out,
  input  logic             alu_compare,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_compare,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   grant;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_carry    <= 1'b0;
      rsp_compare  <= 1'b0;
      ops_done     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            last_grant   <= grant;
            rsp_id       <= grant;
            alu_in_a     <= grant ? req1_a      : req0_a;
            alu_in_b     <= grant ? req1_b      : req0_b;
            alu_select   <= grant ? req1_select : req0_select;
            alu_mode     <= grant ? req1_mode   : req0_mode;
            alu_carry_in <= grant ? req1_carry  : req0_carry;
            state        <= EXEC;
          end
        end
        EXEC: begin
          rsp_data    <= alu_out;
          rsp_carry   <= alu_carry_out;
          rsp_compare <= alu_compare;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: table-driven transactions, directed corner sequences and random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_alu_rr_scheduler;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req0_mode, req0_carry;
  logic [15:0] req0_a, req0_b;
  logic [3:0]  req0_select;
  logic        req1_valid, req1_ready, req1_mode, req1_carry;
  logic [15:0] req1_a, req1_b;
  logic [3:0]  req1_select;
  logic [15:0] alu_in_a, alu_in_b, alu_out, rsp_data, ops_done;
  logic [3:0]  alu_select;
  logic        alu_mode, alu_carry_in, alu_carry_out, alu_compare;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_compare, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_rr_scheduler #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_select(req0_select), .req0_mode(req0_mode), .req0_carry(req0_carry),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_select(req1_select), .req1_mode(req1_mode), .req1_carry(req1_carry),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select), .alu_mode(alu_mode),
    .alu_carry_in(alu_carry_in), .alu_out(alu_out), .alu_carry_out(alu_carry_out),
    .alu_compare(alu_compare), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_compare(rsp_compare), .busy(busy),
    .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: {compare, carry_out, out}. Arithmetic mode adds; logic mode S=F passes A, otherwise XOR.
  function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s, input logic m, input logic c);
    logic [16:0] sum;
    if (!m) begin
      sum = {1'b0, a} + {1'b0, b} + {16'd0, c};
      return {a == b, sum};
    end
    return {a == b, 1'b0, (s == 4'hF) ? a : (a ^ b)};
  endfunction

  always_comb {alu_compare, alu_carry_out, alu_out} = alu_f(alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: what has been accepted, whether a result is being computed or is awaiting pickup.
  logic        m_exec, m_resp, m_last, m_acc, m_acc_id;
  logic [15:0] m_a, m_b, m_data, m_done;
  logic [3:0]  m_sel;
  logic        m_mode, m_cin, m_id, m_cout, m_cmp;

  task automatic model_reset();
    m_exec = 0; m_resp = 0; m_last = 1; m_acc = 0; m_acc_id = 0;
    m_a = 0; m_b = 0; m_sel = 0; m_mode = 0; m_cin = 0;
    m_id = 0; m_data = 0; m_cout = 0; m_cmp = 0; m_done = 0;
  endtask

  function automatic logic winner();
    if (req0_valid && req1_valid) return !m_last;
    return req1_valid;
  endfunction

  task automatic settle();
    logic idle, w;
    #1;
    idle = !m_exec && !m_resp;
    w = winner();
    chk("req0_ready", req0_ready, idle && req0_valid && !w);
    chk("req1_ready", req1_ready, idle && req1_valid && w);
    chk("busy", busy, !idle);
    chk("rsp_valid", rsp_valid, m_resp);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_carry", rsp_carry, m_cout);
    chk("rsp_compare", rsp_compare, m_cmp);
    chk("alu_in_a", alu_in_a, m_a);
    chk("alu_in_b", alu_in_b, m_b);
    chk("alu_ctrl", {alu_select, alu_mode, alu_carry_in}, {m_sel, m_mode, m_cin});
    chk("ops_done", ops_done, m_done);
  endtask

  task automatic advance();
    logic idle, w;
    logic [17:0] r;
    idle = !m_exec && !m_resp;
    w = winner();
    m_acc = 0;
    if (rst) model_reset();
    else if (idle && (req0_valid || req1_valid)) begin
      m_acc = 1; m_acc_id = w; m_last = w; m_id = w; m_exec = 1;
      m_a = w ? req1_a : req0_a;  m_b = w ? req1_b : req0_b;
      m_sel = w ? req1_select : req0_select;
      m_mode = w ? req1_mode : req0_mode;  m_cin = w ? req1_carry : req0_carry;
    end else if (m_exec) begin
      r = alu_f(m_a, m_b, m_sel, m_mode, m_cin);
      {m_cmp, m_cout, m_data} = r;
      m_exec = 0; m_resp = 1;
    end else if (m_resp && rsp_ready) begin
      m_resp = 0; m_done = m_done + 16'd1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic set_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] s, input logic m, input logic c);
    if (!id) begin req0_valid = 1; req0_a = a; req0_b = b; req0_select = s; req0_mode = m; req0_carry = c; end
    else     begin req1_valid = 1; req1_a = a; req1_b = b; req1_select = s; req1_mode = m; req1_carry = c; end
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic wait_accept(input string name);
    int k = 0;
    do begin step(); k++; end while (!m_acc && k < 10);
    if (!m_acc) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    rsp_ready = 1;
    while ((m_exec || m_resp) && k < 10) begin step(); k++; end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] a, b;
    logic [3:0]  sel;
    logic        mode, cin;
    int          stall;
    logic [15:0] exp_data;
    logic        exp_carry, exp_cmp;
  } vec_t;

  vec_t vecs[5];
  logic ids[$];
  int   acc_cyc[$];
  logic [15:0] r1a, r1b;

  initial begin
    vecs[0] = '{0, 16'h0003, 16'h0004, 4'b1001, 0, 0, 0, 16'h0007, 0, 0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 4'b1001, 0, 0, 0, 16'h0000, 1, 0};
    vecs[2] = '{1, 16'hBEEF, 16'hBEEF, 4'b1111, 1, 0, 5, 16'hBEEF, 0, 1};
    vecs[3] = '{0, 16'h00FF, 16'h0F0F, 4'b0000, 1, 1, 2, 16'h0FF0, 0, 0};
    vecs[4] = '{0, 16'h1234, 16'h0001, 4'b1001, 0, 1, 0, 16'h1236, 0, 0};

    model_reset();
    {req0_a, req0_b, req0_select, req0_mode, req0_carry} = '0;
    {req1_a, req1_b, req1_select, req1_mode, req1_carry} = '0;
    @(negedge clk);
    do_reset();
    settle();
    chk("reset_state", {rsp_valid, busy, ops_done, alu_in_a}, 34'd0);

    // Single transactions from the table, some with a stalled consumer.
    foreach (vecs[i]) begin
      rsp_ready = (vecs[i].stall == 0);
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].mode, vecs[i].cin);
      wait_accept("vec");
      chk("vec_accept_id", m_acc_id, vecs[i].id);
      req0_valid = 0; req1_valid = 0;
      step();
      for (int s = 0; s < vecs[i].stall; s++) begin
        settle();
        chk("stall_no_ready", {req0_ready, req1_ready}, 2'b00);
        chk("stall_rsp", {rsp_valid, busy, rsp_data, rsp_compare}, {2'b11, vecs[i].exp_data, vecs[i].exp_cmp});
        advance();
      end
      rsp_ready = 1;
      settle();
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp", {rsp_id, rsp_data, rsp_carry, rsp_compare},
          {vecs[i].id, vecs[i].exp_data, vecs[i].exp_carry, vecs[i].exp_cmp});
      advance();
      settle();
      chk("vec_ops_done", ops_done, 16'(i + 1));
      advance();
    end

    // Both requesters held valid from reset: grants alternate 0,1,0,1 three cycles apart.
    do_reset();
    rsp_ready = 1;
    set_req(0, 16'h1111, 16'h2222, 4'b1001, 0, 0);
    set_req(1, 16'h3333, 16'h3333, 4'b1111, 1, 0);
    for (int k = 0; k < 14 && ids.size() < 4; k++) begin
      step();
      if (m_acc) begin ids.push_back(m_acc_id); acc_cyc.push_back(cyc); end
    end
    chk("rr_count", ids.size(), 4);
    for (int i = 0; i < ids.size(); i++) chk("rr_id", ids[i], i % 2);
    for (int i = 1; i < acc_cyc.size(); i++) chk("rr_gap", acc_cyc[i] - acc_cyc[i-1], 3);
    req0_valid = 0; req1_valid = 0;
    drain();

    // Reset while an operation is in EXEC.
    set_req(1, 16'hAAAA, 16'h5555, 4'b0000, 1, 0);
    wait_accept("mid_rst");
    req1_valid = 0;
    rst = 1;
    step();
    rst = 0;
    settle();
    chk("mid_rst_state", {rsp_valid, busy, alu_in_a, ops_done}, 34'd0);
    advance();
    set_req(0, 16'h0010, 16'h0020, 4'b1001, 0, 0);
    set_req(1, 16'h0030, 16'h0040, 4'b1001, 0, 0);
    wait_accept("post_rst");
    chk("post_rst_first_grant", m_acc_id, 0);
    req0_valid = 0; req1_valid = 0;
    drain();

    // Requester 0 keeps changing operands while requester 1 is served.
    r1a = 16'h0101; r1b = 16'h0202;
    set_req(0, 16'h0000, 16'h0000, 4'b1001, 0, 0);
    set_req(1, r1a, r1b, 4'b1001, 0, 1);
    rsp_ready = 1;
    for (int k = 0; k < 12; k++) begin
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      settle();
      if (rsp_valid && rsp_id == 1'b1) chk("r1_isolated", rsp_data, 16'h0304);
      advance();
      if (m_acc && m_acc_id == 1'b1) req1_valid = 0;
      if (m_acc && m_acc_id == 1'b0) break;
    end
    chk("r0_eventually", m_acc_id, 0);
    req0_valid = 0;
    drain();

    // ops_done wrap: preload the counter, then complete one more handshake.
    @(negedge clk);
    cyc++;
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    m_done = 16'hFFFF;
    set_req(0, 16'h0001, 16'h0001, 4'b1001, 0, 0);
    wait_accept("wrap");
    req0_valid = 0;
    drain();
    settle();
    chk("ops_done_wrap", ops_done, 16'h0000);
    advance();

    // Random traffic with occasional reset; requests held stable until accepted.
    for (int k = 0; k < 2000; k++) begin
      if (!(req0_valid && !(m_acc && m_acc_id == 1'b0)) || m_acc && m_acc_id == 1'b0 || rst) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req0_select = 4'($urandom); req0_mode = 1'($urandom); req0_carry = 1'($urandom);
      end
      if (!(req1_valid && !(m_acc && m_acc_id == 1'b1)) || m_acc && m_acc_id == 1'b1 || rst) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = 16'($urandom); req1_b = ($urandom_range(0, 3) == 0) ? req1_a : 16'($urandom);
        req1_select = 4'($urandom); req1_mode = 1'($urandom); req1_carry = 1'($urandom);
      end
      rsp_ready = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
